aes_stream_engine: RTL
======================

Name: aes_stream_engine

Overview:
- Parametrised successor to the single-shot AES-128 wrapper: a streaming AES-128 encryption engine with ECB and CTR modes.
- Uses valid/ready handshakes on input and output, and a registered key/counter context.
- Has an output FIFO, so downstream back-pressure never drops a block.
- Instantiates the existing combinational AES_Encrypt core once; sits between a DMA-style block source and a packet sink.

Parameters:
- DATA_W, 128: block width. Fixed at 128; the core only supports this width.
- KEY_L, 128: key width. Fixed at 128.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2 and at least 2.
- CTR_W, 32: low counter bits incremented in CTR mode. Range 8..128.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- key_load, input, 1: one-cycle pulse; latches cipher_key, iv and mode.
- cipher_key, input, KEY_L: key, sampled on key_load.
- iv, input, DATA_W: initial counter block, sampled on key_load.
- mode, input, 1: 0 = ECB, 1 = CTR. Sampled on key_load.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: engine can accept a block this cycle.
- in_data, input, DATA_W: plaintext block.
- out_valid, output, 1: FIFO head is valid.
- out_ready, input, 1: sink accepts the head this cycle.
- out_data, output, DATA_W: ciphertext at the FIFO head.
- fifo_count, output, $clog2(FIFO_DEPTH+1): current FIFO occupancy.
- key_valid, output, 1: a key has been loaded since reset.
- ctr_wrap, output, 1: sticky flag; the low CTR_W bits of the counter have wrapped.

Behaviour:

Reset (reset=1 at a rising edge):
- key_reg=0, ctr_reg=0, mode_reg=0.
- key_valid=0, ctr_wrap=0, FIFO emptied, fifo_count=0.
- out_valid=0, out_data=0, in_ready=0.
- Reset mid-stream discards every queued block; nothing is flushed.

Handshakes:
- in_ready = key_valid && (fifo_count < FIFO_DEPTH). It is combinational from registers only, never from out_ready.
- accept = in_valid && in_ready.
- pop = out_valid && out_ready.
- out_valid = (fifo_count != 0). out_data = FIFO head, registered storage.
- When the FIFO is empty, out_data holds the last popped value (0 after reset).

Datapath (combinational, single AES_Encrypt instance):
- ECB: result = AES(in_data, key_reg).
- CTR: result = in_data XOR AES(ctr_reg, key_reg).
- On accept, result is pushed to the FIFO tail.
- Latency: a block accepted at edge N appears on out_data/out_valid after edge N when the FIFO was empty. Otherwise it appears behind earlier entries, in strict FIFO order.

Counter (CTR mode only, on accept):
- ctr_reg[CTR_W-1:0] increments modulo 2^CTR_W. Bits above CTR_W are never modified.
- A transition from all-ones to zero sets ctr_wrap. ctr_wrap stays set until key_load or reset.
- In ECB mode, ctr_reg is unchanged.

key_load:
- Next edge: key_reg<=cipher_key, ctr_reg<=iv, mode_reg<=mode, key_valid<=1, ctr_wrap<=0.
- If accept occurs in the same cycle, that block uses the OLD key, counter and mode. The new context applies from the next cycle, and the old-context counter increment is discarded (ctr_reg takes iv).
- key_load does not flush the FIFO.

FIFO:
- Push and pop in the same cycle: both occur and fifo_count is unchanged.
- Push is impossible when full, because in_ready=0.
- Pop when empty is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH.
- fifo_count never exceeds FIFO_DEPTH.

Error cases:
- in_valid while key_valid=0 is not accepted (in_ready=0). No state changes.

Test Plan:
- ECB known-answer:
  - Stimulus: key_load with key=000102030405060708090a0b0c0d0e0f, mode=0; then in_data=00112233445566778899aabbccddeeff with out_ready=1.
  - Response: one cycle later out_valid=1, out_data=69c4e0d86a7b0430d8cdb78070b4c55a; fifo_count returns to 0.
- CTR keystream:
  - Stimulus: same key, mode=1, iv=00112233445566778899aabbccddeeff; two blocks of in_data=0.
  - Response: first out_data=69c4e0d86a7b0430d8cdb78070b4c55a, second = AES(00112233445566778899aabbccddef00). ctr_reg ends at ...ccddef01.
- Counter wrap:
  - Stimulus: iv=000...00_ffffffff, CTR_W=32, one block accepted.
  - Response: ctr_reg=000...00_00000000 (upper 96 bits untouched), ctr_wrap=1. The next key_load clears ctr_wrap.
- Back-pressure and full FIFO:
  - Stimulus: FIFO_DEPTH=4, out_ready=0, in_valid=1 for 6 cycles.
  - Response: exactly 4 blocks accepted, then in_ready=0 and fifo_count=4. Raising out_ready drains 4 blocks in order; with simultaneous push/pop, fifo_count holds steady.
- key_load collision:
  - Stimulus: accept in the same cycle as key_load with a new key.
  - Response: that output uses the old key; the next block uses the new key and ctr_reg=new iv.
- Reset mid-operation:
  - Stimulus: 3 queued blocks, then assert reset for 1 cycle.
  - Response: fifo_count=0, out_valid=0, key_valid=0, in_ready=0. in_valid is then ignored until the next key_load.

Source files
------------

// File: rtl/AES_Encrypt.sv
// Combinational AES-128 forward cipher: ten rounds and key expansion flattened into one cone.
// Zero latency and no handshake; the caller registers around it.
module AES_Encrypt (
   input  logic [127:0] pt_i,
   input  logic [127:0] key_i,
   output logic [127:0] ct_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
      n0 = rk[127:96] ^ t;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] st;
      logic [127:0] rk;
      logic [7:0]   rc;
      st = pt ^ key;
      rk = key;
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         rk = next_key(rk, rc);
         rc = xtime(rc);
         st = shift_rows(sub_bytes(st));
         if (rnd != 10) st = mix_columns(st);
         st = st ^ rk;
      end
      return st;
   endfunction

   assign ct_o = encrypt(pt_i, key_i);

endmodule

// File: rtl/aes_stream_engine.sv
// Streaming AES-128 ECB/CTR engine: one combinational cipher, a key/counter context and an output FIFO.
// A block accepted at edge N is at the FIFO head after N; in_ready drops only when the FIFO is full.
module aes_stream_engine #(
   parameter int DATA_W     = 128,
   parameter int KEY_L      = 128,
   parameter int FIFO_DEPTH = 4,
   parameter int CTR_W      = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               key_load,
   input  logic [KEY_L-1:0]                   cipher_key,
   input  logic [DATA_W-1:0]                  iv,
   input  logic                               mode,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DATA_W-1:0]                  in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_W-1:0]                  out_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               key_valid,
   output logic                               ctr_wrap
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> (DATA_W - CTR_W);

   typedef struct packed {
      logic [KEY_L-1:0]  key;
      logic [DATA_W-1:0] ctr;
      logic              mode;
   } ctx_t;

   ctx_t               ctx_q, ctx_d;
   logic               key_vld_q, key_vld_d;
   logic               wrap_q, wrap_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  last_q, last_d;
   logic [DATA_W-1:0]  fifo_mem_q [FIFO_DEPTH];

   logic               accept, pop, ctr_ones;
   logic [DATA_W-1:0]  aes_pt, aes_ct, result, head, ctr_inc;

   assign in_ready   = key_vld_q && (cnt_q < CNT_W'(FIFO_DEPTH));
   assign out_valid  = (cnt_q != '0);
   assign accept     = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign head       = fifo_mem_q[rd_ptr_q];
   assign out_data   = out_valid ? head : last_q;
   assign fifo_count = cnt_q;
   assign key_valid  = key_vld_q;
   assign ctr_wrap   = wrap_q;

   AES_Encrypt u_aes (
      .pt_i  (aes_pt),
      .key_i (ctx_q.key),
      .ct_o  (aes_ct)
   );

   // CTR runs the counter through the cipher and XORs the keystream onto the data.
   assign aes_pt   = ctx_q.mode ? ctx_q.ctr : in_data;
   assign result   = ctx_q.mode ? (aes_ct ^ in_data) : aes_ct;
   assign ctr_inc  = (ctx_q.ctr & ~LO_MASK) | ((ctx_q.ctr + DATA_W'(1)) & LO_MASK);
   assign ctr_ones = ((ctx_q.ctr & LO_MASK) == LO_MASK);

   always_comb begin
      ctx_d     = ctx_q;
      key_vld_d = key_vld_q;
      wrap_d    = wrap_q;
      // A same-cycle load wins: the increment earned by the old-context block is dropped.
      if (key_load) begin
         ctx_d.key  = cipher_key;
         ctx_d.ctr  = iv;
         ctx_d.mode = mode;
         key_vld_d  = 1'b1;
         wrap_d     = 1'b0;
      end else if (accept && ctx_q.mode) begin
         ctx_d.ctr = ctr_inc;
         if (ctr_ones) wrap_d = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      last_d   = pop ? head : last_q;
      cnt_d    = cnt_q;
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctx_q     <= '0;
         key_vld_q <= 1'b0;
         wrap_q    <= 1'b0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
      end else begin
         ctx_q     <= ctx_d;
         key_vld_q <= key_vld_d;
         wrap_q    <= wrap_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && accept) fifo_mem_q[wr_ptr_q] <= result;
   end

endmodule
